mcp_controller: RTL

Control unit for the multicycle MIPS-subset processor (mcp).
- A Moore FSM sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives every datapath mux select and write enable, and supplies the 3-bit function code to the shared ALU.
- One ALU is time-shared across PC increment, branch-target add, address generation and execution; this block schedules which use it serves each cycle.

---
 rtl/mcp_defs_pkg.sv | 46 ++++
 rtl/mcp_controller_aludec.sv | 31 +++
 rtl/mcp_controller.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mcp_defs_pkg.sv
// Shared encodings for the multicycle MIPS-subset controller: FSM states, opcodes,
// funct codes, aluop classes and ALU function codes.
package mcp_defs;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_RSVD  = 2'b11
  } aluop_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mcp_controller_aludec.sv
// ALU decoder: maps the FSM's aluop class plus the R-type funct field to an ALU code.
module mcp_aludec
  import mcp_defs::*;
#(
  parameter int unsigned FUNCT_W = 6
) (
  input  aluop_e             aluop,
  input  logic [FUNCT_W-1:0] funct,
  output logic [2:0]         alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: alucontrol = ALU_ADD;
          FUNCT_SUB: alucontrol = ALU_SUB;
          FUNCT_AND: alucontrol = ALU_AND;
          FUNCT_OR:  alucontrol = ALU_OR;
          FUNCT_SLT: alucontrol = ALU_SLT;
          default:   alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mcp_controller.sv
// Multicycle MIPS-subset control unit: Moore FSM sequencing fetch/decode/execute/
// memory/writeback and decoding all datapath selects and enables from the state.
module mcp_controller
  import mcp_defs::*;
#(
  parameter int unsigned OP_W    = 6,
  parameter int unsigned FUNCT_W = 6,
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    op,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               zero,
  output logic               pcen,
  output logic               iord,
  output logic               memwrite,
  output logic               irwrite,
  output logic               regdst,
  output logic               memtoreg,
  output logic               regwrite,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic [2:0]         alucontrol,
  output logic [STATE_W-1:0] state_dbg
);

  state_e state_q;
  aluop_e aluop;
  logic   pcwrite;
  logic   branch;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      case (state_q)
        S_FETCH:  state_q <= S_DECODE;
        S_DECODE: begin
          if (op == OP_LW || op == OP_SW) state_q <= S_MEMADR;
          else if (op == OP_RTYPE)        state_q <= S_EXECUTE;
          else if (op == OP_BEQ)          state_q <= S_BRANCH;
          else if (op == OP_ADDI)         state_q <= S_ADDIEXEC;
          else if (op == OP_J)            state_q <= S_JUMP;
          else                            state_q <= S_FETCH;
        end
        S_MEMADR:   state_q <= (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  state_q <= S_MEMWB;
        S_EXECUTE:  state_q <= S_ALUWB;
        S_ADDIEXEC: state_q <= S_ADDIWB;
        default:    state_q <= S_FETCH;
      endcase
    end
  end

  // Reset forces FETCH's selects but holds every enable low.
  always_comb begin
    pcwrite  = 1'b0;
    branch   = 1'b0;
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    aluop    = ALUOP_ADD;
    if (reset) begin
      alusrcb = 2'b01;
    end else begin
      case (state_q)
        S_FETCH: begin
          irwrite = 1'b1;
          pcwrite = 1'b1;
          alusrcb = 2'b01;
        end
        S_DECODE: alusrcb = 2'b11;
        S_MEMADR: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        S_MEMREAD: iord = 1'b1;
        S_MEMWB: begin
          regwrite = 1'b1;
          memtoreg = 1'b1;
        end
        S_MEMWRITE: begin
          iord     = 1'b1;
          memwrite = 1'b1;
        end
        S_EXECUTE: begin
          alusrca = 1'b1;
          aluop   = ALUOP_FUNCT;
        end
        S_ALUWB: begin
          regwrite = 1'b1;
          regdst   = 1'b1;
        end
        S_BRANCH: begin
          alusrca = 1'b1;
          aluop   = ALUOP_SUB;
          pcsrc   = 2'b01;
          branch  = 1'b1;
        end
        S_ADDIEXEC: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        S_ADDIWB: regwrite = 1'b1;
        S_JUMP: begin
          pcwrite = 1'b1;
          pcsrc   = 2'b10;
        end
        default: ;
      endcase
    end
  end

  assign pcen      = pcwrite | (branch & zero);
  assign state_dbg = reset ? '0 : STATE_W'(state_q);

  mcp_aludec #(
    .FUNCT_W(FUNCT_W)
  ) u_aludec (
    .aluop     (aluop),
    .funct     (funct),
    .alucontrol(alucontrol)
  );

endmodule
